lcd_bus_responder: RTL

- Synthesizable HD44780-style character-LCD responder, 8-bit mode only: the device end of the LCD bus our controllers drive.
- Decodes commands and data latched on falling edges of en_lcd and holds an internal 128-byte DDRAM.
- Answers read cycles with the busy flag and address counter, or with DDRAM data.
- Used on-chip for loopback self-test and as the closed-loop partner for controller benches.

---
 rtl/lcd_pkg.sv | 70 +++++++
 rtl/lcd_edge_sync.sv | 46 ++++
 rtl/lcd_bus_responder.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/lcd_pkg.sv
// lcd_pkg: shared types and constants for the HD44780-style bus responder.
//   - instruction opcode masks (decoded by highest set bit)
//   - responder state enum and decoded-operation enum
//   - stored configuration bits that have no visible effect
//   - busy-time defaults and the blank character used by clear
package lcd_pkg;

    localparam logic [7:0] CMD_CLEAR   = 8'h01;
    localparam logic [7:0] CMD_HOME    = 8'h02;
    localparam logic [7:0] CMD_ENTRY   = 8'h04;
    localparam logic [7:0] CMD_DISPLAY = 8'h08;
    localparam logic [7:0] CMD_SHIFT   = 8'h10;
    localparam logic [7:0] CMD_FUNC    = 8'h20;
    localparam logic [7:0] CMD_CGRAM   = 8'h40;
    localparam logic [7:0] CMD_DDRAM   = 8'h80;

    localparam logic [7:0] SPACE = 8'h20;

    localparam int BUSY_CYCLES_DEF      = 2000;
    localparam int BUSY_LONG_CYCLES_DEF = 82000;

    typedef enum logic [1:0] {
        ST_OFF,
        ST_CLEAR_FILL,
        ST_BUSY,
        ST_IDLE
    } lcd_state_e;

    typedef enum logic [3:0] {
        OP_NOP,
        OP_CLEAR,
        OP_HOME,
        OP_ENTRY,
        OP_DISPLAY,
        OP_SHIFT,
        OP_FUNC,
        OP_CGRAM,
        OP_DDRAM
    } lcd_op_e;

    // Cursor/blink and function-set fields are held but do not change behaviour.
    typedef struct packed {
        logic cursor;
        logic blink;
        logic dl;
        logic lines;
        logic font;
    } lcd_cfg_t;

    // Instruction class is chosen by the highest set bit of the byte.
    function automatic lcd_op_e decode_op(input logic [7:0] cmd);
        lcd_op_e op;
        op = OP_NOP;
        if (|(cmd & CMD_DDRAM))        op = OP_DDRAM;
        else if (|(cmd & CMD_CGRAM))   op = OP_CGRAM;
        else if (|(cmd & CMD_FUNC))    op = OP_FUNC;
        else if (|(cmd & CMD_SHIFT))   op = OP_SHIFT;
        else if (|(cmd & CMD_DISPLAY)) op = OP_DISPLAY;
        else if (|(cmd & CMD_ENTRY))   op = OP_ENTRY;
        else if (|(cmd & CMD_HOME))    op = OP_HOME;
        else if (cmd == CMD_CLEAR)     op = OP_CLEAR;
        return op;
    endfunction

    // Address counter is 7-bit modulo in both directions.
    function automatic logic [6:0] ac_step(input logic [6:0] ac, input logic inc);
        return inc ? (ac + 7'd1) : (ac - 7'd1);
    endfunction

endpackage

// File: rtl/lcd_edge_sync.sv
// lcd_edge_sync: synchronizes the asynchronous bus strobe and flags its falling edge.
//   clk      in   system clock
//   rst      in   synchronous active-low clear
//   en_async in   raw bus strobe
//   en_sync  out  strobe after SYNC_STAGES flops
//   en_fall  out  one-cycle pulse, the cycle after en_sync goes 1 -> 0
module lcd_edge_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic en_async,
    output logic en_sync,
    output logic en_fall
);

    if (SYNC_STAGES < 2) begin : g_stage_check
        $error("lcd_edge_sync needs at least two synchronizer stages");
    end

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic en_prev_q, en_prev_d;
    logic fall_q, fall_d;

    assign en_sync = sync_q[SYNC_STAGES-1];
    assign en_fall = fall_q;

    always_comb begin
        sync_d    = {sync_q[SYNC_STAGES-2:0], en_async};
        en_prev_d = en_sync;
        fall_d    = en_prev_q & ~en_sync;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            sync_q    <= '0;
            en_prev_q <= 1'b0;
            fall_q    <= 1'b0;
        end else begin
            sync_q    <= sync_d;
            en_prev_q <= en_prev_d;
            fall_q    <= fall_d;
        end
    end

endmodule

// File: rtl/lcd_bus_responder.sv
// lcd_bus_responder: device end of an 8-bit HD44780-style character LCD bus.
//   clk, rst          system clock, synchronous active-low reset
//   on_lcd            panel power; low behaves like reset (DDRAM kept)
//   rs_lcd, rw_lcd    register select / read-not-write
//   en_lcd            asynchronous bus strobe
//   data_in           byte driven by the controller
//   data_out, data_oe byte driven back and its enable (tristate built above)
//   busy              busy flag BF
//   display_on        D bit of display control
//   init_done         sticky, set by a function set with DL = 1
//   proto_err         sticky, a write arrived while busy
//   dbg_addr/dbg_data registered DDRAM debug read, 1-cycle latency
//
// state         | meaning
// ST_OFF        | held in reset / unpowered; leaves on the first running cycle
// ST_CLEAR_FILL | writing SPACE to DDRAM[0..127], one entry per clk, BF = 1
// ST_BUSY       | counting down the busy timer, BF = 1 until it reaches 0
// ST_IDLE       | BF = 0, writes accepted
module lcd_bus_responder
    import lcd_pkg::*;
#(
    parameter int CLK_HZ           = 50_000_000,
    parameter int BUSY_CYCLES      = BUSY_CYCLES_DEF,
    parameter int BUSY_LONG_CYCLES = BUSY_LONG_CYCLES_DEF,
    parameter int SYNC_STAGES      = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       on_lcd,
    input  logic       rs_lcd,
    input  logic       rw_lcd,
    input  logic       en_lcd,
    input  logic [7:0] data_in,
    output logic [7:0] data_out,
    output logic       data_oe,
    output logic       busy,
    output logic       display_on,
    output logic       init_done,
    output logic       proto_err,
    input  logic [6:0] dbg_addr,
    output logic [7:0] dbg_data
);

    if (CLK_HZ <= 0 || BUSY_CYCLES < 1 || BUSY_LONG_CYCLES < BUSY_CYCLES) begin : g_param_check
        $error("lcd_bus_responder: invalid clock or busy-time parameters");
    end

    localparam int CNT_W = $clog2(BUSY_LONG_CYCLES + 1);
    localparam logic [CNT_W-1:0] SHORT_LOAD = CNT_W'(BUSY_CYCLES);
    localparam logic [CNT_W-1:0] LONG_LOAD  = CNT_W'(BUSY_LONG_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam logic [6:0]       FILL_LAST  = 7'd127;

    logic run;
    logic en_sync, en_fall;

    lcd_state_e state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [6:0] fill_idx_q, fill_idx_d;
    logic pwr_fill_q, pwr_fill_d;
    logic [6:0] ac_q, ac_d;
    logic id_q, id_d;
    lcd_cfg_t cfg_q, cfg_d;
    logic display_on_q, display_on_d;
    logic init_done_q, init_done_d;
    logic proto_err_q, proto_err_d;
    logic bus_rs_q, bus_rs_d;
    logic bus_rw_q, bus_rw_d;
    logic [7:0] bus_data_q, bus_data_d;
    logic data_oe_q, data_oe_d;
    logic [7:0] data_out_q, data_out_d;
    logic [7:0] dbg_data_q, dbg_data_d;

    logic [7:0] mem [128];
    logic       mem_we;
    logic [6:0] mem_waddr;
    logic [7:0] mem_wdata;

    logic    bf;
    logic    wr_ok;
    lcd_op_e op;

    // Power-off is folded into the synchronous reset; DDRAM is never cleared by it.
    assign run = rst & on_lcd;

    lcd_edge_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_edge_sync (
        .clk      (clk),
        .rst      (run),
        .en_async (en_lcd),
        .en_sync  (en_sync),
        .en_fall  (en_fall)
    );

    // BF drops in the same cycle the counter hits zero, so a write landing
    // then is accepted.
    assign bf    = (state_q == ST_CLEAR_FILL) || (state_q == ST_BUSY && cnt_q != '0);
    assign wr_ok = (state_q == ST_IDLE) || (state_q == ST_BUSY && cnt_q == '0);

    assign busy       = bf;
    assign data_out   = data_out_q;
    assign data_oe    = data_oe_q;
    assign display_on = display_on_q;
    assign init_done  = init_done_q;
    assign proto_err  = proto_err_q;
    assign dbg_data   = dbg_data_q;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        fill_idx_d   = fill_idx_q;
        pwr_fill_d   = pwr_fill_q;
        ac_d         = ac_q;
        id_d         = id_q;
        cfg_d        = cfg_q;
        display_on_d = display_on_q;
        init_done_d  = init_done_q;
        proto_err_d  = proto_err_q;
        mem_we       = 1'b0;
        mem_waddr    = ac_q;
        mem_wdata    = bus_data_q;
        op           = decode_op(bus_data_q);

        // Bus lines are captured every cycle; at en_fall they hold the values
        // from the cycle in which the synchronized strobe fell.
        bus_rs_d   = rs_lcd;
        bus_rw_d   = rw_lcd;
        bus_data_d = data_in;

        data_oe_d  = en_sync & rw_lcd;
        data_out_d = 8'h00;
        if (data_oe_d) begin
            data_out_d = rs_lcd ? mem[ac_q] : {bf, ac_q};
        end
        dbg_data_d = mem[dbg_addr];

        case (state_q)
            ST_OFF: begin
                state_d    = ST_CLEAR_FILL;
                fill_idx_d = '0;
                cnt_d      = LONG_LOAD;
                pwr_fill_d = 1'b1;
                ac_d       = '0;
                id_d       = 1'b1;
            end
            ST_CLEAR_FILL: begin
                mem_we     = 1'b1;
                mem_waddr  = fill_idx_q;
                mem_wdata  = SPACE;
                fill_idx_d = fill_idx_q + 7'd1;
                // A clear command starts its long busy time at acceptance;
                // the power-up fill holds it until the fill is done.
                if (!pwr_fill_q && cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_ONE;
                end
                if (fill_idx_q == FILL_LAST) begin
                    state_d    = ST_BUSY;
                    pwr_fill_d = 1'b0;
                end
            end
            ST_BUSY: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_ONE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
            end
        endcase

        if (en_fall && state_q != ST_OFF) begin
            if (bus_rw_q) begin
                if (bus_rs_q) begin
                    ac_d = ac_step(ac_q, id_q);
                end
            end else if (!wr_ok) begin
                proto_err_d = 1'b1;
            end else if (bus_rs_q) begin
                mem_we    = 1'b1;
                mem_waddr = ac_q;
                mem_wdata = bus_data_q;
                ac_d      = ac_step(ac_q, id_q);
                cnt_d     = SHORT_LOAD;
                state_d   = ST_BUSY;
            end else begin
                cnt_d   = SHORT_LOAD;
                state_d = ST_BUSY;
                case (op)
                    OP_CLEAR: begin
                        state_d    = ST_CLEAR_FILL;
                        fill_idx_d = '0;
                        pwr_fill_d = 1'b0;
                        cnt_d      = LONG_LOAD;
                        ac_d       = '0;
                        id_d       = 1'b1;
                    end
                    OP_HOME: begin
                        cnt_d = LONG_LOAD;
                        ac_d  = '0;
                    end
                    OP_ENTRY: begin
                        id_d = bus_data_q[1];
                    end
                    OP_DISPLAY: begin
                        display_on_d = bus_data_q[2];
                        cfg_d.cursor = bus_data_q[1];
                        cfg_d.blink  = bus_data_q[0];
                    end
                    OP_SHIFT: begin
                        if (!bus_data_q[3]) begin
                            ac_d = ac_step(ac_q, bus_data_q[2]);
                        end
                    end
                    OP_FUNC: begin
                        cfg_d.dl    = bus_data_q[4];
                        cfg_d.lines = bus_data_q[3];
                        cfg_d.font  = bus_data_q[2];
                        if (bus_data_q[4]) begin
                            init_done_d = 1'b1;
                        end
                    end
                    OP_DDRAM: begin
                        ac_d = bus_data_q[6:0];
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst || !on_lcd) begin
            state_q      <= ST_OFF;
            cnt_q        <= '0;
            fill_idx_q   <= '0;
            pwr_fill_q   <= 1'b0;
            ac_q         <= '0;
            id_q         <= 1'b1;
            cfg_q        <= '0;
            display_on_q <= 1'b0;
            init_done_q  <= 1'b0;
            proto_err_q  <= 1'b0;
            bus_rs_q     <= 1'b0;
            bus_rw_q     <= 1'b0;
            bus_data_q   <= '0;
            data_oe_q    <= 1'b0;
            data_out_q   <= '0;
            dbg_data_q   <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            fill_idx_q   <= fill_idx_d;
            pwr_fill_q   <= pwr_fill_d;
            ac_q         <= ac_d;
            id_q         <= id_d;
            cfg_q        <= cfg_d;
            display_on_q <= display_on_d;
            init_done_q  <= init_done_d;
            proto_err_q  <= proto_err_d;
            bus_rs_q     <= bus_rs_d;
            bus_rw_q     <= bus_rw_d;
            bus_data_q   <= bus_data_d;
            data_oe_q    <= data_oe_d;
            data_out_q   <= data_out_d;
            dbg_data_q   <= dbg_data_d;
        end
    end

    // Read ports sample before this write lands, so a same-cycle read sees old data.
    always_ff @(posedge clk) begin
        if (mem_we && run) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

endmodule
